// File: rtl/sound_mix_seq_if.sv
// sound_mix_seq_if: load/ready handshake between the channel-mixing sequencer
// (master) and the serial volume multiplier-accumulator (slave).
interface sound_mix_seq_if;
    logic [5:0]  mac_vol;      // channel volume presented with the load pulse
    logic [7:0]  mac_dat;      // channel sample (sign-inverted format)
    logic        mac_load;     // one-cycle load pulse
    logic        mac_clr_sum;  // restart accumulation; meaningful only with mac_load
    logic        mac_ready;    // MAC finished the last load
    logic [15:0] mac_sum;      // running accumulated sum

    modport master (
        output mac_vol, mac_dat, mac_load, mac_clr_sum,
        input  mac_ready, mac_sum
    );

    modport slave (
        input  mac_vol, mac_dat, mac_load, mac_clr_sum,
        output mac_ready, mac_sum
    );
endinterface

// File: rtl/sound_mix_seq.sv
// sound_mix_seq: on each sample tick, walks every channel twice (left group,
// then right group), feeds each group member to the MAC one at a time and
// publishes the two accumulated sums as a stereo pair.
// Optional feature macro: MIX_OVERRUN_EN adds a sticky overrun flag raised by
// a start tick that arrives while a mix is still in progress.
module sound_mix_seq #(
    parameter int             NCH       = 8,
    parameter int             CW        = 3,
    parameter logic [NCH-1:0] LEFT_MASK = 'h0F
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [CW-1:0]         ch_sel,
    input  logic [5:0]            vol_in,
    input  logic [7:0]            dat_in,
    sound_mix_seq_if.master       mac,
    output logic [15:0]           left_out,
    output logic [15:0]           right_out,
    output logic                  out_stb,
`ifdef MIX_OVERRUN_EN
    input  logic                  ovr_clr,
    output logic                  overrun,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, SCAN, LOAD, WAIT, STORE, DONE} state_t;
    typedef enum logic {PASS_L, PASS_R} pass_t;

    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t        state_q, state_d;
    pass_t         pass_q, pass_d;
    logic [CW-1:0] ch_sel_q, ch_sel_d;
    logic          first_q, first_d;
    logic [15:0]   hold_l_q, hold_l_d;
    logic [15:0]   left_q, left_d;
    logic [15:0]   right_q, right_d;

    logic          in_group;
    logic          last_ch;
    logic [15:0]   store_val;

    // A channel is part of the current pass when its mask bit matches the pass side.
    assign in_group  = (LEFT_MASK[ch_sel_q] == (pass_q == PASS_L));
    assign last_ch   = (ch_sel_q == LAST_CH);
    // An empty group never touched the MAC, so its stale sum must not leak out.
    assign store_val = first_q ? 16'h0000 : mac.mac_sum;

    // Next-state and datapath updates for the scan/load/wait/store sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d  = state_q;
        pass_d   = pass_q;
        ch_sel_d = ch_sel_q;
        first_d  = first_q;
        hold_l_d = hold_l_q;
        left_d   = left_q;
        right_d  = right_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d   = PASS_L;
                    ch_sel_d = '0;
                    first_d  = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (in_group) begin
                    state_d = LOAD;
                end else if (last_ch) begin
                    state_d = STORE;
                end else begin
                    ch_sel_d = ch_sel_q + CW'(1);
                end
            end
            LOAD: begin
                first_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mac.mac_ready) begin
                    if (last_ch) begin
                        state_d = STORE;
                    end else begin
                        ch_sel_d = ch_sel_q + CW'(1);
                        state_d  = SCAN;
                    end
                end
            end
            STORE: begin
                if (pass_q == PASS_L) begin
                    hold_l_d = store_val;
                    pass_d   = PASS_R;
                    ch_sel_d = '0;
                    first_d  = 1'b1;
                    state_d  = SCAN;
                end else begin
                    left_d  = hold_l_q;
                    right_d = store_val;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; partial sums are dropped on reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            pass_q   <= PASS_L;
            ch_sel_q <= '0;
            first_q  <= 1'b1;
            hold_l_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            ch_sel_q <= ch_sel_d;
            first_q  <= first_d;
            hold_l_q <= hold_l_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

`ifdef MIX_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky overrun: a start tick during a mix sets it, and set beats clear.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr) overrun_d = 1'b0;
        if (start && (state_q != IDLE)) overrun_d = 1'b1;
    end

    // Overrun flag register.
    always_ff @(posedge clock) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    assign ch_sel          = ch_sel_q;
    assign mac.mac_vol     = vol_in;
    assign mac.mac_dat     = dat_in;
    assign mac.mac_load    = (state_q == LOAD);
    assign mac.mac_clr_sum = (state_q == LOAD) && first_q;
    assign left_out        = left_q;
    assign right_out       = right_q;
    assign out_stb         = (state_q == DONE);
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_sound_mix_seq.sv
// tb_sound_mix_seq: two sequencers (left mask 8'h0F and 8'hFF) run side by side
// on a shared channel table, each with its own MAC stand-in. A mix-level model
// predicts busy/out_stb/left_out/right_out every cycle; directed mixes pin the
// model with hand-computed values, then randomized mixes follow.
module tb_sound_mix_seq;
    localparam int NCH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  vol_tab [NCH];
    logic [7:0]  dat_tab [NCH];
    int          mac_delay = 16;

    logic [2:0]  ch_sel    [2];
    logic [15:0] left_out  [2];
    logic [15:0] right_out [2];
    logic        out_stb   [2];
    logic        busy      [2];
    logic        ld        [2];
    logic        clr       [2];
`ifdef MIX_OVERRUN_EN
    logic        ovr_clr = 1'b0;
    logic        overrun [2];
    logic        m_ovr   [2];
`endif

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;

    // Mix-level model state, one entry per DUT.
    logic        m_active [2];
    int          m_stb    [2];
    logic [15:0] m_left   [2];
    logic [15:0] m_right  [2];
    logic [15:0] m_pl     [2];
    logic [15:0] m_pr     [2];
    int          loads    [2];
    int          stb_seen [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sound_mix_seq_if bus ();
        int          cnt = 0;
        logic [15:0] sum = '0;

        sound_mix_seq #(
            .NCH       (NCH),
            .CW        (3),
            .LEFT_MASK ((g == 0) ? 8'h0F : 8'hFF)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start),
            .ch_sel    (ch_sel[g]),
            .vol_in    (vol_tab[ch_sel[g]]),
            .dat_in    (dat_tab[ch_sel[g]]),
            .mac       (bus.master),
            .left_out  (left_out[g]),
            .right_out (right_out[g]),
            .out_stb   (out_stb[g]),
`ifdef MIX_OVERRUN_EN
            .ovr_clr   (ovr_clr),
            .overrun   (overrun[g]),
`endif
            .busy      (busy[g])
        );

        // MAC stand-in: signed product of volume and (sample - 128), 16-bit wrap,
        // ready mac_delay cycles after the load.
        always @(posedge clock) begin
            if (bus.mac_load) begin
                cnt <= mac_delay - 1;
                sum <= 16'(bus.mac_clr_sum
                           ? int'(bus.mac_vol) * (int'(bus.mac_dat) - 128)
                           : int'(sum) + int'(bus.mac_vol) * (int'(bus.mac_dat) - 128));
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
            end
        end

        assign bus.mac_ready = (cnt == 0);
        assign bus.mac_sum   = sum;
        assign ld[g]         = bus.mac_load;
        assign clr[g]        = bus.mac_clr_sum;
    end

    function automatic logic [7:0] mask_of(int k);
        return (k == 0) ? 8'h0F : 8'hFF;
    endfunction

    // Sum of vol * signed sample over one group, wrapped to 16 bits.
    function automatic logic [15:0] mix_sum(logic [7:0] m, logic left);
        int s = 0;
        for (int n = 0; n < NCH; n++)
            if (m[n] == left) s += int'(vol_tab[n]) * (int'(dat_tab[n]) - 128);
        return 16'(s);
    endfunction

    // Cycles from the start tick to out_stb: two full scans, every channel
    // loaded once (load + delay), two stores, one done.
    function automatic int mix_len();
        return 2 * NCH + (mac_delay + 1) * NCH + 3;
    endfunction

    function automatic int first_of(logic [7:0] m, int ch);
        for (int n = 0; n < NCH; n++)
            if (m[n] == m[ch]) return n;
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic        eb, es;
        logic [15:0] el, er;
        for (int k = 0; k < 2; k++) begin
            eb = m_active[k] && (cyc <= m_stb[k]);
            es = m_active[k] && (cyc == m_stb[k]);
            el = es ? m_pl[k] : m_left[k];
            er = es ? m_pr[k] : m_right[k];
            check($sformatf("busy%0d", k), 32'(busy[k]), 32'(eb));
            check($sformatf("out_stb%0d", k), 32'(out_stb[k]), 32'(es));
            check($sformatf("left_out%0d", k), 32'(left_out[k]), 32'(el));
            check($sformatf("right_out%0d", k), 32'(right_out[k]), 32'(er));
            if (ld[k]) begin
                check($sformatf("clr_sum%0d", k), 32'(clr[k]),
                      32'(int'(ch_sel[k]) == first_of(mask_of(k), int'(ch_sel[k]))));
                loads[k]++;
            end
            if (es) begin
                check($sformatf("load_count%0d", k), 32'(loads[k]), 32'(NCH));
                stb_seen[k] = cyc;
            end
`ifdef MIX_OVERRUN_EN
            check($sformatf("overrun%0d", k), 32'(overrun[k]), 32'(m_ovr[k]));
`endif
            if (reset) begin
                m_active[k] = 1'b0;
                m_left[k]   = '0;
                m_right[k]  = '0;
`ifdef MIX_OVERRUN_EN
                m_ovr[k]    = 1'b0;
`endif
            end else begin
`ifdef MIX_OVERRUN_EN
                if (start && eb) m_ovr[k] = 1'b1;
                else if (ovr_clr) m_ovr[k] = 1'b0;
`endif
                if (start && !eb) begin
                    m_active[k] = 1'b1;
                    m_stb[k]    = cyc + mix_len();
                    m_pl[k]     = mix_sum(mask_of(k), 1'b1);
                    m_pr[k]     = mix_sum(mask_of(k), 1'b0);
                    loads[k]    = 0;
                end
                if (es) begin
                    m_left[k]   = m_pl[k];
                    m_right[k]  = m_pr[k];
                    m_active[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Pulses start for one cycle; returns the cycle in which start was high.
    task automatic pulse_start(output int s);
        s = cyc;
        stb_seen[0] = -1;
        stb_seen[1] = -1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy[0] || busy[1]) && n < bound);
        if (n >= bound) check("idle_timeout", 32'(busy[0] | busy[1]), 32'd0);
        tick(1);
    endtask

    task automatic set_tables(logic [5:0] vl, logic [5:0] vr, logic [7:0] dl, logic [7:0] dr);
        for (int n = 0; n < NCH; n++) begin
            vol_tab[n] = (n < 4) ? vl : vr;
            dat_tab[n] = (n < 4) ? dl : dr;
        end
    endtask

    initial begin
        int s;
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_left[k]   = '0;
            m_right[k]  = '0;
            loads[k]    = 0;
            stb_seen[k] = -1;
`ifdef MIX_OVERRUN_EN
            m_ovr[k]    = 1'b0;
`endif
        end
        set_tables(6'd63, 6'd63, 8'hFF, 8'h00);
        fork
            forever begin
                @(negedge clock);
                if (mon_en) compare();
            end
        join_none

        tick(3);
        reset = 1'b0;
        check("ch_sel_after_reset", 32'(ch_sel[0]), 32'd0);
        mon_en = 1'b1;
        tick(2);

        // Default mix: left = 4*63*127, right = 4*63*(-128).
        pulse_start(s);
        wait_idle(1000);
        check("s1_left0", 32'(left_out[0]), 32'h7D04);
        check("s1_right0", 32'(right_out[0]), 32'h8200);
        check("s1_left1", 32'(left_out[1]), 32'hFF04);
        check("s1_right1", 32'(right_out[1]), 32'h0000);
        check("s1_stb_lat0", 32'(stb_seen[0] - s), 32'd155);

        // Left channels muted: left mix collapses to zero, right unchanged.
        set_tables(6'd0, 6'd63, 8'hFF, 8'h00);
        pulse_start(s);
        wait_idle(1000);
        check("s2_left0", 32'(left_out[0]), 32'h0000);
        check("s2_right0", 32'(right_out[0]), 32'h8200);
        check("s2_left1", 32'(left_out[1]), 32'h8200);

        // All channels full scale: all-left mask wraps 8*8001, empty right group gives 0.
        set_tables(6'd63, 6'd63, 8'hFF, 8'hFF);
        pulse_start(s);
        wait_idle(1000);
        check("s3_left1", 32'(left_out[1]), 32'hFA08);
        check("s3_right1", 32'(right_out[1]), 32'h0000);
        check("s3_stb_lat1", 32'(stb_seen[1] - s), 32'd155);
        check("s3_right0", 32'(right_out[0]), 32'h7D04);

        // Start re-pulsed at +50 and +100 while busy: ignored.
        set_tables(6'd63, 6'd63, 8'hFF, 8'h00);
        pulse_start(s);
        tick(s + 50 - cyc);
        start = 1'b1; tick(1); start = 1'b0;
        tick(s + 100 - cyc);
        start = 1'b1; tick(1); start = 1'b0;
        wait_idle(1000);
        check("s4_left0", 32'(left_out[0]), 32'h7D04);
        check("s4_right0", 32'(right_out[0]), 32'h8200);
        check("s4_stb_lat0", 32'(stb_seen[0] - s), 32'd155);
`ifdef MIX_OVERRUN_EN
        check("s4_overrun_set", 32'(overrun[0]), 32'd1);
        ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0; tick(1);
        check("s4_overrun_clr", 32'(overrun[0]), 32'd0);
`endif

        // Reset at cycle 90 of a mix, then a clean mix.
        pulse_start(s);
        tick(s + 90 - cyc);
        reset = 1'b1; tick(1); reset = 1'b0;
        @(negedge clock);
        check("s5_left_rst", 32'(left_out[0]), 32'h0000);
        check("s5_right_rst", 32'(right_out[0]), 32'h0000);
        check("s5_busy_rst", 32'(busy[0]), 32'd0);
        tick(1);
        pulse_start(s);
        wait_idle(1000);
        check("s5_left0", 32'(left_out[0]), 32'h7D04);
        check("s5_right0", 32'(right_out[0]), 32'h8200);

        // Slower MAC: 4 extra cycles for each of the 8 loads.
        mac_delay = 20;
        pulse_start(s);
        wait_idle(1000);
        check("s6_stb_lat0", 32'(stb_seen[0] - s), 32'd187);
        check("s6_left0", 32'(left_out[0]), 32'h7D04);

        // Randomized mixes with random tables, MAC latency, stray starts and resets.
        for (int it = 0; it < 24; it++) begin
            for (int n = 0; n < NCH; n++) begin
                vol_tab[n] = 6'($urandom);
                dat_tab[n] = 8'($urandom);
            end
            mac_delay = $urandom_range(1, 24);
            pulse_start(s);
            if ($urandom_range(0, 4) == 0) begin
                tick($urandom_range(1, 150));
                reset = 1'b1; tick(1); reset = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                tick($urandom_range(1, 120));
                start = 1'b1; tick(1); start = 1'b0;
            end
            wait_idle(2000);
            tick($urandom_range(0, 3));
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
